heading: RTL and testbench

HEADING -- requirements
Module: heading

---
 rtl/heading.sv | 93 +++++++++
 tb/tb_heading.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/heading.sv
// rtl/heading.sv - key-gated header router
// Unlock with KEY, capture one header byte, route its 7-bit payload to P or Q.
module heading #(
  parameter logic [2:0] KEY = 3'b111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       confirm,
  input  logic [7:0] inputData,
  input  logic [2:0] din,
  output logic [6:0] dataP,
  output logic [6:0] dataQ,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    ARMED   = 3'b001,
    LOAD    = 3'b010,
    ROUTE_P = 3'b011,
    ROUTE_Q = 3'b100,
    DONE    = 3'b101,
    ERROR   = 3'b110,
    UNUSED  = 3'b111
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] hdr_q, hdr_d;
  logic [6:0] data_p_q, data_p_d;
  logic [6:0] data_q_q, data_q_d;

  // Route bit is consumed at capture time; the stored copy is kept only for completeness.
  logic unused_hdr_route;
  assign unused_hdr_route = hdr_q[7];

  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    data_p_d = data_p_q;
    data_q_d = data_q_q;
    case (state_q)
      IDLE: begin
        if (confirm && din == KEY) state_d = ARMED;
      end
      ARMED: begin
        state_d = confirm ? LOAD : IDLE;
      end
      LOAD: begin
        if (confirm) begin
          hdr_d = inputData;
          if (inputData[6:0] == 7'd0) state_d = ERROR;
          else if (inputData[7])      state_d = ROUTE_P;
          else                        state_d = ROUTE_Q;
        end else begin
          state_d = IDLE;
        end
      end
      ROUTE_P: begin
        data_p_d = hdr_q[6:0];
        state_d  = DONE;
      end
      ROUTE_Q: begin
        data_q_d = hdr_q[6:0];
        state_d  = DONE;
      end
      DONE, ERROR: begin
        state_d = state_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      hdr_q    <= 8'd0;
      data_p_q <= 7'd0;
      data_q_q <= 7'd0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      data_p_q <= data_p_d;
      data_q_q <= data_q_d;
    end
  end

  assign state = state_q;
  assign dataP = data_p_q;
  assign dataQ = data_q_q;

endmodule

// File: tb/tb_heading.sv
// tb/tb_heading.sv - directed self-checking bench for heading
module tb_heading;

  logic       clk;
  logic       rst;
  logic       confirm;
  logic [7:0] inputData;
  logic [2:0] din;
  logic [6:0] dataP;
  logic [6:0] dataQ;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  heading #(.KEY(3'b111)) dut (
    .clk       (clk),
    .rst       (rst),
    .confirm   (confirm),
    .inputData (inputData),
    .din       (din),
    .dataP     (dataP),
    .dataQ     (dataQ),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Walks IDLE->ARMED->LOAD->route->terminal; din and inputData are scrambled outside their windows.
  task automatic run_flow(input logic [7:0] hdr, input logic [2:0] route_st, input logic [2:0] end_st);
    confirm   = 1'b1;
    din       = 3'b111;
    inputData = 8'h00;
    tick();
    check("armed", {5'd0, state}, 8'd1);
    din = 3'b010;
    tick();
    check("load", {5'd0, state}, 8'd2);
    inputData = hdr;
    tick();
    check("route_state", {5'd0, state}, {5'd0, route_st});
    inputData = 8'hFF;
    check("pre_route_p", {1'b0, dataP}, 8'd0);
    check("pre_route_q", {1'b0, dataQ}, 8'd0);
    if (route_st != 3'd6) begin
      tick();
      check("terminal", {5'd0, state}, {5'd0, end_st});
    end
  endtask

  initial begin
    rst       = 1'b0;
    confirm   = 1'bx;
    din       = 3'bxxx;
    inputData = 8'hxx;
    tick();
    check("rst_state", {5'd0, state}, 8'd0);
    check("rst_p", {1'b0, dataP}, 8'd0);
    check("rst_q", {1'b0, dataQ}, 8'd0);
    rst = 1'b1;

    // Route P with sticky DONE
    run_flow(8'b10101111, 3'd3, 3'd5);
    check("p1_dataP", {1'b0, dataP}, 8'h2F);
    check("p1_dataQ", {1'b0, dataQ}, 8'h00);
    confirm = 1'b0; din = 3'b111; inputData = 8'h55;
    tick();
    confirm = 1'b1;
    tick();
    check("done_sticky", {5'd0, state}, 8'd5);
    check("done_hold_p", {1'b0, dataP}, 8'h2F);

    do_reset();
    check("p2_reset_p", {1'b0, dataP}, 8'h00);
    run_flow(8'b10110001, 3'd3, 3'd5);
    check("p2_dataP", {1'b0, dataP}, 8'h31);
    check("p2_dataQ", {1'b0, dataQ}, 8'h00);

    // Route Q, twice
    do_reset();
    run_flow(8'b00101111, 3'd4, 3'd5);
    check("q1_dataQ", {1'b0, dataQ}, 8'h2F);
    check("q1_dataP", {1'b0, dataP}, 8'h00);
    do_reset();
    run_flow(8'b00100001, 3'd4, 3'd5);
    check("q2_dataQ", {1'b0, dataQ}, 8'h21);

    // Wrong key, then right key without confirm
    do_reset();
    confirm = 1'b1; din = 3'b101;
    tick(); tick();
    check("wrong_key", {5'd0, state}, 8'd0);
    confirm = 1'b0; din = 3'b111;
    tick();
    check("no_confirm", {5'd0, state}, 8'd0);
    check("wk_p", {1'b0, dataP}, 8'd0);

    // Null payload -> sticky ERROR
    do_reset();
    run_flow(8'b10000000, 3'd6, 3'd6);
    confirm = 1'b0; inputData = 8'h81;
    tick(); tick();
    check("error_sticky", {5'd0, state}, 8'd6);
    check("err_p", {1'b0, dataP}, 8'd0);
    check("err_q", {1'b0, dataQ}, 8'd0);
    do_reset();
    check("err_reset", {5'd0, state}, 8'd0);

    // Abort from ARMED
    confirm = 1'b1; din = 3'b111;
    tick();
    check("ab_armed", {5'd0, state}, 8'd1);
    confirm = 1'b0;
    tick();
    check("ab_armed_idle", {5'd0, state}, 8'd0);

    // Abort from LOAD with a null byte present: must not go to ERROR
    confirm = 1'b1;
    tick(); tick();
    check("ab_load", {5'd0, state}, 8'd2);
    confirm = 1'b0; inputData = 8'h00;
    tick();
    check("ab_load_idle", {5'd0, state}, 8'd0);
    confirm = 1'b1; din = 3'b011;
    tick();
    check("fresh_key", {5'd0, state}, 8'd0);

    // Reset during ROUTE_P beats the payload copy
    run_flow(8'b11111111, 3'd3, 3'd5);
    do_reset();
    check("route_after", {5'd0, state}, 8'd0);
    check("route_after_p", {1'b0, dataP}, 8'd0);
    confirm = 1'b1; din = 3'b111;
    tick(); tick();
    inputData = 8'b11111111;
    tick();
    check("mid_route", {5'd0, state}, 8'd3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_state", {5'd0, state}, 8'd0);
    check("mid_rst_p", {1'b0, dataP}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
